// File: rtl/sha1_stream_pkg.sv
// sha1_stream_pkg: shared state encoding and sizes for the SHA-1 word-stream receiver.
package sha1_stream_pkg;
    localparam int WORDS  = 16;
    localparam int DATA_W = 32;
    localparam int DIG_W  = 160;
    localparam int BLK_W  = 512;
    localparam int IDX_W  = $clog2(WORDS);
    typedef enum logic [1:0] {IDLE, FILL, ISSUE, WAIT_CORE} state_t;
endpackage

// File: rtl/sha1_word_assembler.sv
// sha1_word_assembler: packs streamed words into a 512-bit block, word 0 in the top bits.
module sha1_word_assembler
    import sha1_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load0,
    input  logic              i_loadn,
    input  logic [DATA_W-1:0] i_data,
    output logic [BLK_W-1:0]  o_block,
    output logic              o_last
);
    logic [BLK_W-1:0] r_block;
    logic [IDX_W-1:0] r_count;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block <= '0;
            r_count <= '0;
        end else if (i_load0) begin
            r_block[BLK_W-1 -: DATA_W] <= i_data;
            r_count <= IDX_W'(1);
        end else if (i_loadn) begin
            r_block[BLK_W-1-DATA_W*int'(r_count) -: DATA_W] <= i_data;
            r_count <= r_count + 1'b1;
        end
    end
    assign o_block = r_block;
    assign o_last  = r_count == IDX_W'(WORDS-1);
endmodule

// File: rtl/sha1_stream_receiver.sv
// sha1_stream_receiver: collects 16-word blocks, hands them to a SHA-1 core and latches the digest.
module sha1_stream_receiver
    import sha1_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_initial,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_ready,
    output logic [DIG_W-1:0]  out_digest,
    output logic              blk_valid,
    output logic [BLK_W-1:0]  blk_data,
    input  logic              blk_accept,
    input  logic              core_done,
    input  logic [DIG_W-1:0]  core_digest,
    output logic              proto_err,
    output logic              err_sticky,
    output logic [31:0]       blocks_done
);
    state_t            r_state;
    logic              r_ready, r_blk_valid, r_err, r_sticky;
    logic [DIG_W-1:0]  r_digest;
    logic [31:0]       r_blocks;
    logic              w_load0, w_loadn, w_last, w_err;
    logic              w_filling;
    assign w_filling = r_state == FILL;
    assign w_load0   = in_valid & in_initial & (r_state == IDLE | w_filling);
    assign w_loadn   = in_valid & ~in_initial & w_filling;
    // Any word the FSM cannot store, and any stray core completion, is a violation.
    assign w_err = (in_valid & ~w_load0 & ~w_loadn) | (in_valid & in_initial & w_filling)
                 | (core_done & r_state != WAIT_CORE);
    sha1_word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .i_load0 (w_load0),
        .i_loadn (w_loadn),
        .i_data  (in_data),
        .o_block (blk_data),
        .o_last  (w_last)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_blk_valid <= 1'b0;
            r_digest    <= '0;
            r_blocks    <= '0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_err    <= w_err;
            r_sticky <= r_sticky | w_err;
            case (r_state)
                IDLE: if (w_load0) begin
                    r_state <= FILL;
                    r_ready <= 1'b0;
                end
                FILL: if (w_loadn && w_last) begin
                    r_state     <= ISSUE;
                    r_blk_valid <= 1'b1;
                end
                ISSUE: if (blk_accept) begin
                    r_state     <= WAIT_CORE;
                    r_blk_valid <= 1'b0;
                end
                WAIT_CORE: if (core_done) begin
                    r_state  <= IDLE;
                    r_ready  <= 1'b1;
                    r_digest <= core_digest;
                    r_blocks <= r_blocks + 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign out_ready   = r_ready;
    assign out_digest  = r_digest;
    assign blk_valid   = r_blk_valid;
    assign proto_err   = r_err;
    assign err_sticky  = r_sticky;
    assign blocks_done = r_blocks;
endmodule

// File: tb/tb_sha1_stream_receiver.sv
// tb_sha1_stream_receiver: randomized checks of the receiver against a word-queue reference model.
module tb_sha1_stream_receiver;
    logic          clk = 0, reset = 1;
    logic          in_initial = 0, in_valid = 0;
    logic [31:0]   in_data = 0;
    logic          out_ready, blk_valid, proto_err, err_sticky;
    logic [159:0]  out_digest, core_digest = 0;
    logic [511:0]  blk_data;
    logic          blk_accept = 0, core_done = 0;
    logic [31:0]   blocks_done;

    int            checks = 0, errors = 0;
    logic [31:0]   mq[$];
    logic [159:0]  exp_dig = 0;
    logic [31:0]   exp_blocks = 0;
    logic          exp_sticky = 0;

    sha1_stream_receiver dut (
        .clk(clk), .reset(reset), .in_initial(in_initial), .in_valid(in_valid),
        .in_data(in_data), .out_ready(out_ready), .out_digest(out_digest),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_accept(blk_accept),
        .core_done(core_done), .core_digest(core_digest), .proto_err(proto_err),
        .err_sticky(err_sticky), .blocks_done(blocks_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] model_blk();
        logic [511:0] r = '0;
        for (int i = 0; i < mq.size(); i++) r[511-32*i -: 32] = mq[i];
        return r;
    endfunction

    task automatic idle_status(input string tag);
        chk({tag, "_ready"}, out_ready, 1);
        chk({tag, "_digest"}, out_digest, exp_dig);
        chk({tag, "_blocks"}, blocks_done, exp_blocks);
        chk({tag, "_sticky"}, err_sticky, exp_sticky);
    endtask

    task automatic send(input logic [31:0] d, input bit ini, input int gap);
        bit e;
        e = ini && mq.size() > 0;
        in_valid = 1; in_initial = ini; in_data = d;
        tick();
        in_valid = 0; in_initial = 0;
        if (ini) mq.delete();
        mq.push_back(d);
        exp_sticky |= e;
        chk("word_err", proto_err, e);
        chk("word_sticky", err_sticky, exp_sticky);
        chk("word_ready", out_ready, 0);
        chk("word_bv", blk_valid, mq.size() == 16);
        if (mq.size() == 16) chk("blk_data", blk_data, model_blk());
        repeat (gap) tick();
    endtask

    task automatic send_block(input int gap);
        for (int i = 0; i < 16; i++) send($urandom, i == 0, gap);
    endtask

    task automatic core_xact(input int acc_d, input int core_d, input logic [159:0] dg, input bit stray);
        logic [511:0] b;
        b = model_blk();
        for (int i = 0; i < acc_d; i++) begin
            in_valid = stray && i == 0; in_data = $urandom;
            tick();
            in_valid = 0;
            exp_sticky |= stray && i == 0;
            chk("hold_err", proto_err, stray && i == 0);
            chk("hold_bv", blk_valid, 1);
            chk("hold_data", blk_data, b);
        end
        blk_accept = 1;
        tick();
        blk_accept = 0;
        chk("accept_bv", blk_valid, 0);
        for (int i = 0; i < core_d; i++) begin
            tick();
            chk("core_ready", out_ready, 0);
        end
        core_done = 1; core_digest = dg;
        tick();
        core_done = 0; core_digest = {5{$urandom}};
        exp_dig = dg; exp_blocks++;
        mq.delete();
        chk("done_err", proto_err, 0);
        idle_status("done");
    endtask

    initial begin
        logic [511:0] ref_blk;
        repeat (2) tick();
        chk("rst_bv", blk_valid, 0);
        chk("rst_bdata", blk_data, 0);
        chk("rst_err", proto_err, 0);
        idle_status("rst");
        reset = 0;
        tick();

        for (int i = 0; i < 16; i++) send(i, i == 0, 0);
        chk("w0_bits", blk_data[511:480], 0);
        chk("w15_bits", blk_data[31:0], 32'hF);
        ref_blk = blk_data;
        core_xact(5, 10, 160'hDA39A3EE5E6B4B0D3255BFEF95601890AFD80709, 0);

        for (int i = 0; i < 16; i++) send(i, i == 0, 3);
        chk("gap_same", blk_data, ref_blk);
        core_xact(1, 4, {5{$urandom}}, 0);

        for (int i = 0; i < 7; i++) send($urandom, i == 0, 0);
        send(32'hCAFEF00D, 1, 0);
        for (int i = 0; i < 15; i++) send($urandom, 0, $urandom_range(0, 1));
        chk("restart_w0", blk_data[511:480], 32'hCAFEF00D);
        core_xact(2, 3, {5{$urandom}}, 0);

        in_valid = 1; in_data = $urandom;
        tick();
        in_valid = 0;
        chk("idle_word_err", proto_err, 1);
        idle_status("idle_word");
        core_done = 1; core_digest = {5{$urandom}};
        tick();
        core_done = 0;
        chk("idle_core_err", proto_err, 1);
        idle_status("idle_core");
        tick();
        chk("idle_err_clr", proto_err, 0);

        for (int k = 0; k < 4; k++) begin
            send_block($urandom_range(0, 2));
            core_xact($urandom_range(1, 4), $urandom_range(0, 6), {5{$urandom}}, k[0]);
        end

        send_block(0);
        blk_accept = 1;
        tick();
        blk_accept = 0;
        repeat (3) tick();
        reset = 1;
        #1;
        exp_dig = 0; exp_blocks = 0; exp_sticky = 0; mq.delete();
        chk("mid_rst_bv", blk_valid, 0);
        chk("mid_rst_bdata", blk_data, 0);
        idle_status("mid_rst");
        tick();
        reset = 0;
        core_done = 1; core_digest = {5{$urandom}};
        tick();
        core_done = 0;
        exp_sticky = 1;
        chk("late_core_err", proto_err, 1);
        idle_status("late_core");

        send_block(1);
        core_xact(1, 2, {5{$urandom}}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sha1_stream_receiver.md
Name: sha1_stream_receiver

Overview:
Receiver end of the SHA-1 word-stream interface (initial/valid/data in, ready/digest out) that the collision searcher drives. It assembles 16 streamed 32-bit words into one 512-bit block and hands the block to a SHA-1 compression core over a valid/accept handshake. It then latches the returned 160-bit digest and presents it to the producer with the ready level it waits on. It sits between the collision searcher and the compression core.

Parameters:
WORDS, 16, 32-bit words per block
DATA_W, 32, stream word width
DIG_W, 160, digest width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_initial  in  1  marks word 0 of a new block; qualified by in_valid
in_valid  in  1  in_data carries a word this cycle
in_data  in  32  stream word
out_ready  out  1  high = idle, digest valid, next block may start
out_digest  out  160  digest of last completed block
blk_valid  out  1  block presented to core
blk_data  out  512  assembled block, word 0 in bits 511:480
blk_accept  in  1  core takes block (blk_valid & blk_accept)
core_done  in  1  one-cycle pulse, core_digest valid
core_digest  in  160  digest from core
proto_err  out  1  one-cycle pulse on protocol violation
err_sticky  out  1  set by any proto_err, cleared only by reset
blocks_done  out  32  completed blocks, wraps at 2^32

Behaviour:
- Reset (any time, including mid-block or mid-core): state IDLE, out_ready=1, out_digest=0, blk_valid=0, blk_data=0, word count=0, proto_err=0, err_sticky=0, blocks_done=0. Any partial block is discarded.
- FSM states:
  - IDLE: out_ready=1.
    - in_valid&in_initial: store word 0, count=1, go FILL, out_ready=0 from next cycle.
    - in_valid&~in_initial: word dropped, proto_err pulse.
  - FILL: each in_valid stores the word at index count, then count+1. Gaps (in_valid=0) are allowed and hold state.
    - in_valid&in_initial in FILL: proto_err pulse; that word becomes word 0; count=1 (restart).
    - Storing word index 15: go ISSUE. blk_valid=1 on the next cycle.
  - ISSUE: blk_valid=1 and blk_data stable until blk_accept. On blk_valid&blk_accept, go WAIT_CORE; blk_valid=0 next cycle. in_valid here: word dropped, proto_err pulse.
  - WAIT_CORE: wait for core_done. On core_done at cycle M:
    - out_digest<=core_digest, blocks_done+1, go IDLE.
    - out_ready=1 at M+1.
    - in_valid here: dropped, proto_err pulse.
- core_done while not in WAIT_CORE: ignored; no digest update; proto_err pulse.
- out_digest holds its value until the next accepted core_done.
- Latency: word 15 accepted at cycle N, blk_valid=1 at N+1. Minimum out_ready low time is 16 words + 1 issue cycle + core latency + 1.
- out_ready falls exactly once per block. Each accepted block yields one 1→0 and one 0→1 transition, which the producer's digest tracker counts.
- Word count is 4 bits. It never wraps inside FILL: index 15 always exits.
- All outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package sha1_stream_pkg:
  - state encodings IDLE/FILL/ISSUE/WAIT_CORE
  - WORDS, DATA_W, DIG_W, BLK_W=512
  - word-index width
- One natural sub-module, sha1_word_assembler: 512-bit block register plus word counter. Inputs: load-word-0, load-word-n, data. Outputs: block, last_word flag.
- The FSM, handshakes, digest latch and counters stay in the top module.

Test Plan:
- Reset, then 16 words 0x00000000..0x0000000F with in_initial on word 0 -> blk_valid one cycle after word 15; blk_data[511:480]=0x0, blk_data[31:0]=0xF; out_ready=0 from the cycle after word 0.
- Hold blk_accept low 5 cycles, then pulse; core_done 10 cycles later with digest 0xDA39A3EE5E6B4B0D3255BFEF95601890AFD80709 -> blk_data stable throughout; out_digest matches and out_ready=1 one cycle after core_done; blocks_done=1.
- Word stream with 3-cycle gaps between every word -> identical blk_data to the gap-free case.
- in_initial asserted again at word 7 -> proto_err pulse, err_sticky=1; block completes 15 words later with the restarted word in bits 511:480.
- in_valid without in_initial in IDLE, plus a core_done pulse in IDLE -> both proto_err pulses; out_digest, blocks_done and out_ready unchanged.
- reset asserted during WAIT_CORE, then a late core_done -> all outputs return to reset values; the late core_done is ignored; out_digest=0.
